// File: rtl/vx_tcu_fedp_ctrl.sv
// vx_tcu_fedp_ctrl: issue/drain controller around one fixed-latency, enable-gated FEDP lane
//   req_*  : valid/ready request stream (fmt_s, fmt_d, a_row, b_col, c_val, tag)
//   fedp_* : enable plus combinational operand pass-through to the FEDP, fedp_d_val result back
//   rsp_*  : valid/ready response stream from the output FIFO head (d_val, tag, err)
//   busy   : any op in flight or buffered
module vx_tcu_fedp_ctrl #(
  parameter int N          = 4,
  parameter int LATENCY    = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int OBUF_DEPTH = 2,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_fmt_s,
  input  logic [2:0]            req_fmt_d,
  input  logic [N*XLEN-1:0]     req_a_row,
  input  logic [N*XLEN-1:0]     req_b_col,
  input  logic [XLEN-1:0]       req_c_val,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  fedp_enable,
  output logic [2:0]            fedp_fmt_s,
  output logic [2:0]            fedp_fmt_d,
  output logic [N*XLEN-1:0]     fedp_a_row,
  output logic [N*XLEN-1:0]     fedp_b_col,
  output logic [XLEN-1:0]       fedp_c_val,
  input  logic [XLEN-1:0]       fedp_d_val,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_d_val,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int PW = $clog2(OBUF_DEPTH);
  if (LATENCY < 1 || OBUF_DEPTH < 2) begin : g_param_check
    $error("vx_tcu_fedp_ctrl: LATENCY must be >=1 and OBUF_DEPTH >=2");
  end
  logic [LATENCY-1:0]   pv, pe;
  logic [TAG_WIDTH-1:0] pt [LATENCY];
  logic [XLEN-1:0]      od [OBUF_DEPTH];
  logic [TAG_WIDTH-1:0] ot [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] oe;
  logic [PW-1:0]        rp, wp;
  logic [CW-1:0]        count;
  logic full, stall, req_fire, fmt_err, push, pop;
  assign fedp_fmt_s = req_fmt_s;
  assign fedp_fmt_d = req_fmt_d;
  assign fedp_a_row = req_a_row;
  assign fedp_b_col = req_b_col;
  assign fedp_c_val = req_c_val;
  // Full comes from the count register only, so rsp_ready never reaches req_ready/fedp_enable.
  assign full        = count == CW'(OBUF_DEPTH);
  assign stall       = pv[LATENCY-1] && full;
  assign req_ready   = !stall && !reset;
  assign req_fire    = req_valid && req_ready;
  assign fedp_enable = !stall && !reset && (req_valid || |pv);
  assign fmt_err     = req_fmt_s == 3'd0 || req_fmt_s > 3'd3;
  assign push        = fedp_enable && pv[LATENCY-1];
  assign pop         = rsp_valid && rsp_ready;
  assign rsp_valid   = count != '0;
  assign rsp_d_val   = od[rp];
  assign rsp_tag     = ot[rp];
  assign rsp_err     = oe[rp];
  assign busy        = |pv || rsp_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv    <= '0;
      pe    <= '0;
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      // Shadow pipe tracks the FEDP exactly: it moves only when the FEDP moves.
      if (fedp_enable) begin
        pv <= (pv << 1) | LATENCY'(req_fire);
        pe <= (pe << 1) | LATENCY'(fmt_err);
      end
      if (push) wp <= wp == PW'(OBUF_DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= rp == PW'(OBUF_DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (fedp_enable) begin
      pt[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) pt[i] <= pt[i-1];
    end
    if (push) begin
      od[wp] <= pe[LATENCY-1] ? '0 : fedp_d_val;
      ot[wp] <= pt[LATENCY-1];
      oe[wp] <= pe[LATENCY-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full));
      assert (!(pop && count == '0));
    end
  end
endmodule

// File: tb/tb_vx_tcu_fedp_ctrl.sv
// tb_vx_tcu_fedp_ctrl: randomized + directed bench with an in-order response scoreboard
module tb_vx_tcu_fedp_ctrl;
  localparam int N = 4, L = 16, TW = 8, X = 32;
  logic clk = 0, reset;
  logic req_valid, req_ready, fedp_enable, rsp_valid, rsp_ready, rsp_err, busy;
  logic [2:0] req_fmt_s, req_fmt_d, fedp_fmt_s, fedp_fmt_d;
  logic [N*X-1:0] req_a_row, req_b_col, fedp_a_row, fedp_b_col;
  logic [X-1:0] req_c_val, fedp_c_val, fedp_d_val, rsp_d_val;
  logic [TW-1:0] req_tag, rsp_tag;
  always #5 clk = ~clk;
  vx_tcu_fedp_ctrl #(.N(N), .LATENCY(L), .TAG_WIDTH(TW), .OBUF_DEPTH(2), .XLEN(X)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt_s(req_fmt_s), .req_fmt_d(req_fmt_d), .req_a_row(req_a_row), .req_b_col(req_b_col),
    .req_c_val(req_c_val), .req_tag(req_tag), .fedp_enable(fedp_enable),
    .fedp_fmt_s(fedp_fmt_s), .fedp_fmt_d(fedp_fmt_d), .fedp_a_row(fedp_a_row),
    .fedp_b_col(fedp_b_col), .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d_val(rsp_d_val), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err), .busy(busy));
  // Stand-in FEDP: a pure function of its operands, delayed by L enabled cycles.
  // The test-plan fp16 vector (8 pairs of 1.0*2.0 plus 1.0) yields its true result 17.0.
  function automatic logic [X-1:0] dot(logic [N*X-1:0] a, logic [N*X-1:0] b, logic [X-1:0] c);
    if (a == {N{32'h3C003C00}} && b == {N{32'h40004000}} && c == 32'h3F800000) return 32'h41880000;
    return a[31:0] ^ a[N*X-1 -: 32] ^ b[63:32] ^ {c[15:0], c[31:16]} ^ 32'h1234_5678;
  endfunction
  bit [X-1:0] fp [L];
  always @(posedge clk)
    if (fedp_enable) begin
      fp[0] <= dot(fedp_a_row, fedp_b_col, fedp_c_val);
      for (int i = 1; i < L; i++) fp[i] <= fp[i-1];
    end
  assign fedp_d_val = fp[L-1];
  typedef struct { logic [X-1:0] d; logic [TW-1:0] tag; logic err; } rsp_t;
  rsp_t q[$];
  int vecs = 0, errs = 0;
  int ncyc = 0, acc_cyc = 0, first_rsp = -1, last_rsp = 0, n_rsp = 0;
  bit fired, stalled;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask
  // Samples one cycle's worth of DUT behaviour just after the inputs settle, then waits a clock.
  task automatic tick();
    rsp_t e;
    bit ok;
    #1;
    if (!reset) begin
      check("busy", busy, q.size() != 0);
      if (!rsp_valid) check("ready_when_empty", req_ready, 1);
      if (!req_valid && q.size() == 0) check("enable_idle", fedp_enable, 0);
      if (req_valid && !rsp_valid) check("enable_issue", fedp_enable, 1);
      if (rsp_valid && rsp_ready) begin
        check("rsp_pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_err", rsp_err, e.err);
          check("rsp_d_val", rsp_d_val, e.d);
        end
        if (first_rsp < 0) first_rsp = ncyc;
        last_rsp = ncyc;
        n_rsp++;
      end
    end
    fired = req_valid && req_ready && !reset;
    if (req_valid && !req_ready && !reset) stalled = 1;
    if (fired) begin
      ok = req_fmt_s inside {3'd1, 3'd2, 3'd3};
      acc_cyc = ncyc;
      q.push_back('{d: ok ? dot(req_a_row, req_b_col, req_c_val) : '0, tag: req_tag, err: !ok});
    end
    ncyc++;
    @(negedge clk);
  endtask
  task automatic set_op(logic [2:0] fs, logic [TW-1:0] tag);
    req_valid = 1;
    req_fmt_s = fs;
    req_fmt_d = 3'($urandom);
    req_a_row = {$urandom, $urandom, $urandom, $urandom};
    req_b_col = {$urandom, $urandom, $urandom, $urandom};
    req_c_val = $urandom;
    req_tag   = tag;
  endtask
  task automatic drain(int lim);
    int k = 0;
    req_valid = 0;
    rsp_ready = 1;
    while ((q.size() != 0 || busy) && k < lim) begin tick(); k++; end
    check("drain_done", q.size(), 0);
  endtask
  task automatic phase_start();
    first_rsp = -1;
    n_rsp = 0;
    stalled = 0;
  endtask
  task automatic single_fp16(logic [TW-1:0] tag, string nm);
    phase_start();
    req_valid = 1; req_fmt_s = 3'd1; req_fmt_d = 3'd0; req_tag = tag;
    req_a_row = {N{32'h3C003C00}}; req_b_col = {N{32'h40004000}}; req_c_val = 32'h3F800000;
    rsp_ready = 1;
    tick();
    check({nm, "_accept"}, fired, 1);
    drain(60);
    check({nm, "_latency"}, first_rsp - acc_cyc, L + 1);
    check({nm, "_count"}, n_rsp, 1);
  endtask
  initial begin
    reset = 1; req_valid = 1; rsp_ready = 1;
    set_op(3'd1, 8'h00);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_enable", fedp_enable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 0; req_valid = 0;
    #1;
    check("post_rst_ready", req_ready, 1);
    @(negedge clk);
    single_fp16(8'h5A, "fp16");
    // 20 back-to-back ops, consumer always ready
    phase_start();
    for (int i = 0; i < 20; i++) begin set_op(3'(1 + i % 3), TW'(i)); tick(); end
    drain(100);
    check("b2b_stall_seen", stalled, 0);
    check("b2b_rsp_count", n_rsp, 20);
    check("b2b_rsp_run", last_rsp - first_rsp, 19);
    // Same stream with the consumer blocked for 30 cycles after the first accept
    phase_start();
    begin
      int issued = 0, t0 = -1, k = 0;
      while (issued < 20 && k < 300) begin
        set_op(3'(1 + issued % 3), TW'(issued));
        rsp_ready = (t0 < 0 || ncyc - t0 < 30) ? 0 : 1;
        if (t0 < 0) rsp_ready = 0;
        tick();
        if (fired) begin if (t0 < 0) t0 = ncyc - 1; issued++; end
        k++;
      end
      check("stall_issued", issued, 20);
    end
    drain(300);
    check("stall_seen", stalled, 1);
    check("stall_rsp_count", n_rsp, 20);
    // Illegal source format between two legal ops
    phase_start();
    set_op(3'd1, 8'hA0); tick();
    set_op(3'd5, 8'hA1); tick();
    set_op(3'd2, 8'hA2); tick();
    drain(100);
    check("fmt_rsp_count", n_rsp, 3);
    // Reset while 3 ops are in flight
    for (int i = 0; i < 3; i++) begin set_op(3'd3, TW'(8'hC0 + i)); tick(); end
    req_valid = 0;
    repeat (7) tick();
    set_op(3'd1, 8'hEE);
    reset = 1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_enable", fedp_enable, 0);
    check("mid_rst_ready", req_ready, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 0; req_valid = 0;
    #1;
    check("rel_rst_ready", req_ready, 1);
    check("rel_rst_busy", busy, 0);
    @(negedge clk);
    phase_start();
    repeat (30) tick();
    check("no_stale_rsp", n_rsp, 0);
    single_fp16(8'h77, "post_rst");
    // Idle: nothing requested
    req_valid = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("idle_enable", fedp_enable, 0);
      check("idle_busy", busy, 0);
    end
    // Randomized traffic with random backpressure and random formats
    for (int i = 0; i < 600; i++) begin
      set_op(3'($urandom_range(0, 7)), TW'($urandom));
      req_valid = $urandom_range(0, 3) != 0;
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    drain(400);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/vx_tcu_fedp_ctrl.md
Name: VX_tcu_fedp_ctrl

Overview:
- Issue/drain controller that sits directly upstream and downstream of one TCU fused dot-product (FEDP) lane.
- Converts a valid/ready request stream into the FEDP's enable-gated, fixed-latency pipeline.
- Tracks in-flight ops with a valid/tag shadow pipeline and captures FEDP results into a small output FIFO.
- Stalls the FEDP (enable low) only when a completing result has nowhere to go, and idles it when empty.

Parameters:
N, 4, FEDP dot-product width in XLEN words (2*N fp16/bf16 pairs or N tf32 pairs)
LATENCY, 16, FEDP total latency in enabled cycles; must equal FEDP's TOTAL_LATENCY for the same N (16 for N=4); >=1
TAG_WIDTH, 8, opaque request tag carried alongside each op
OBUF_DEPTH, 2, output FIFO entries; >=2

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_fmt_s  in  3  source format: 1=fp16, 2=bf16, 3=tf32
req_fmt_d  in  3  destination format, passed through
req_a_row  in  N*XLEN  A operands
req_b_col  in  N*XLEN  B operands
req_c_val  in  XLEN  accumulator input (fp32)
req_tag  in  TAG_WIDTH  request tag
fedp_enable  out  1  FEDP pipeline advance
fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val  out  (as req)  combinational pass-through of req_* to FEDP
fedp_d_val  in  XLEN  FEDP result
rsp_valid  out  1  response valid (FIFO head)
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_d_val  out  XLEN  result; 0 when rsp_err
rsp_tag  out  TAG_WIDTH  tag of the op
rsp_err  out  1  op was issued with illegal fmt_s
busy  out  1  any op in flight or buffered

Behaviour:
- Shadow pipe: pv[0..LATENCY-1] valid bits plus tag/err per stage. It shifts only when fedp_enable=1: stage0 <= req_fire, stage k <= stage k-1.
- stall = pv[LATENCY-1] && obuf_full. obuf_full is the registered condition count==OBUF_DEPTH. rsp_ready has no combinational path to req_ready or fedp_enable.
- req_ready = !stall && !reset.
- req_fire = req_valid && req_ready.
- fedp_enable = !stall && (req_valid || |pv). FEDP is held (enable=0) when fully idle.
- Bubble issue: enable=1 with no req_fire injects pv[0]=0. FEDP inputs are don't-care for that slot.
- Completion: when fedp_enable=1 and pv[LATENCY-1]=1, push {fedp_d_val, tag, err} into the FIFO that same cycle. fedp_d_val is sampled while the last shadow stage is valid, matching the FEDP output timing.
- Latency: an op accepted in cycle t with no stalls has rsp_valid high at t+LATENCY+1 (FEDP LATENCY cycles plus 1 FIFO write cycle).
- Every stall cycle delays all in-flight ops by exactly one cycle. Ordering is strictly FIFO; tags are never reordered.
- FIFO: circular buffer with wrapping read/write pointers and count register.
  - Push and pop in the same cycle leave count unchanged.
  - If full with pop and completion both pending in the same cycle, the completion still stalls that cycle (one-cycle penalty, accepted).
  - Push never occurs when full.
- Illegal fmt_s (0, 4..7): the op is accepted and issued normally. Its err bit is set in the shadow pipe, and at push rsp_d_val is forced to 0 with rsp_err=1. The FEDP output is discarded.
- busy = |pv || count!=0.
- Throughput: 1 op/cycle when rsp_ready is held high; steady-state count never exceeds 1.
- Reset (async, any time including mid-operation):
  - pv cleared, count/pointers cleared.
  - rsp_valid=0, busy=0, fedp_enable=0, req_ready=0 while reset is asserted.
  - In-flight ops are dropped with no response.
  - First cycle after deassert: req_ready=1.
- Assertions:
  - LATENCY>=1, OBUF_DEPTH>=2.
  - No push when full.
  - No pop when empty.

Test Plan:
- Single fp16 op, N=4: a words 0x3C003C00 (1.0,1.0), b words 0x40004000 (2.0,2.0), c=0x3F800000, tag=0x5A, rsp_ready=1 -> rsp_valid exactly LATENCY+1 cycles after accept, rsp_d_val=0x41880000 (17.0), rsp_tag=0x5A, rsp_err=0.
- 20 back-to-back ops, tags 0..19, rsp_ready=1 -> req_ready stays 1, 20 consecutive rsp_valid cycles with tags 0..19 in order, fedp_enable drops to 0 one cycle after the last op completes.
- Same 20 ops with rsp_ready=0 for 30 cycles after the first accept -> FIFO fills to 2, fedp_enable/req_ready drop when pv[LATENCY-1]=1 and full. After release, all 20 results are delivered in order with none lost or duplicated, and values match the unstalled run.
- fmt_s=5 op between two legal ops -> middle response has rsp_err=1, rsp_d_val=0, correct tag; neighbours are unaffected.
- Assert reset 7 cycles after issuing 3 ops -> rsp_valid, busy, fedp_enable and req_ready go to 0 immediately; no stale responses appear after deassert. A new op then completes with normal latency.
- Idle: no req_valid for 50 cycles after drain -> fedp_enable=0, busy=0 throughout.
